// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch/PC unit and the datapath.
package pc_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        EXEC,
        TRAP
    } pc_state_t;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_plus4.sv
// 32-bit wrapping next-sequential-PC adder.
module pc_plus4
    import pc_pkg::*;
(
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_plus4
);

    assign o_pc_plus4 = i_pc + 32'(INSTR_BYTES);

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch controller: request, wait for data, hold until retire,
// select the next PC and trap on misaligned targets.
module fetch_pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        retire,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        trap,
    output logic [31:0] trap_pc
);

    pc_state_t   r_state;
    pc_state_t   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic [31:0] r_trap_pc;
    logic [31:0] w_pc_plus4;
    logic        w_misaligned;
    logic        w_instr_load;
    logic        w_trap_capture;

    pc_plus4 u_pc_plus4 (
        .i_pc       (r_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    assign w_misaligned   = (PCTarget[1:0] != 2'b00);
    assign w_instr_load   = (r_state == WAIT) && imem_rsp_valid;
    assign w_trap_capture = (r_state == EXEC) && retire && PCSrc && w_misaligned;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            REQ: begin
                if (imem_req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                if (retire) begin
                    if (!PCSrc) begin
                        w_pc_next    = w_pc_plus4;
                        w_state_next = REQ;
                    end else if (!w_misaligned) begin
                        w_pc_next    = PCTarget;
                        w_state_next = REQ;
                    end else begin
                        // PC stays on the faulting instruction until TRAP redirects it.
                        w_state_next = TRAP;
                    end
                end
            end
            TRAP: begin
                w_pc_next    = TRAP_VECTOR;
                w_state_next = REQ;
            end
            default: begin
                w_state_next = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= REQ;
            r_pc      <= RESET_VECTOR;
            r_instr   <= 32'h0;
            r_trap_pc <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_instr_load) begin
                r_instr <= imem_rsp_data;
            end
            if (w_trap_capture) begin
                r_trap_pc <= PCTarget;
            end
        end
    end

    assign imem_req_valid = (r_state == REQ);
    assign imem_addr      = r_pc;
    assign instr_valid    = (r_state == EXEC);
    assign Instr          = r_instr;
    assign PC             = r_pc;
    assign PCPlus4        = w_pc_plus4;
    assign trap           = (r_state == TRAP);
    assign trap_pc        = r_trap_pc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected fetch addresses are queued at retire time and
// checked when the DUT's request is accepted.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        retire;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        trap;
    logic [31:0] trap_pc;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_trap_pc;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .retire         (retire),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .trap           (trap),
        .trap_pc        (trap_pc)
    );

    // Starts at a fresh negedge where the DUT must already be in REQ; stalls ready for
    // `stall` cycles, then accepts and returns `data` on the following cycle.
    task automatic fetch_one(input logic [31:0] data, input int stall);
        logic [31:0] exp_addr;
        @(negedge clk);
        retire = 1'b0;
        PCSrc  = 1'b0;
        n_cmp++;
        if (trap !== 1'b0) begin
            n_fail++; $display("FAIL trap_clear: got %b want 0", trap);
        end
        n_cmp++;
        if (trap_pc !== exp_trap_pc) begin
            n_fail++; $display("FAIL trap_pc_hold: got %h want %h", trap_pc, exp_trap_pc);
        end
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            exp_addr = 32'hx;
        end else begin
            exp_addr = exp_q.pop_front();
        end
        for (int i = 0; i < stall; i++) begin
            imem_req_ready = 1'b0;
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b addr=%h iv=%b want 1 %h 0",
                         i, imem_req_valid, imem_addr, instr_valid, exp_addr);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_accept: got valid=%b addr=%h iv=%b want 1 %h 0",
                     imem_req_valid, imem_addr, instr_valid, exp_addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: got valid=%b iv=%b want 0 0", imem_req_valid, instr_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_instr      = data;
    endtask

    // Observes EXEC, then retires with the given redirect; queues the next expected address.
    task automatic retire_one(input logic src, input logic [31:0] target);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hBAD0_BAD0;
        n_cmp++;
        if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_state: got iv=%b rv=%b trap=%b want 1 0 0",
                     instr_valid, imem_req_valid, trap);
        end
        n_cmp++;
        if (Instr !== exp_instr) begin
            n_fail++; $display("FAIL instr: got %h want %h", Instr, exp_instr);
        end
        n_cmp++;
        if (PC !== model_pc || PCPlus4 !== model_pc + 32'd4) begin
            n_fail++;
            $display("FAIL exec_pc: got pc=%h p4=%h want %h %h",
                     PC, PCPlus4, model_pc, model_pc + 32'd4);
        end
        retire   = 1'b1;
        PCSrc    = src;
        PCTarget = target;
        if (!src) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back(model_pc);
        end else if (target[1:0] == 2'b00) begin
            model_pc = target;
            exp_q.push_back(model_pc);
        end else begin
            exp_trap_pc = target;
            @(negedge clk);
            retire = 1'b0;
            n_cmp++;
            if (trap !== 1'b1 || trap_pc !== target || PC !== model_pc ||
                imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_cycle: got trap=%b tpc=%h pc=%h rv=%b iv=%b want 1 %h %h 0 0",
                         trap, trap_pc, PC, imem_req_valid, instr_valid, target, model_pc);
            end
            model_pc = TV;
            exp_q.push_back(model_pc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 || trap !== 1'b0 ||
            trap_pc !== 32'h0 || PC !== RV || Instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vals: got rv=%b iv=%b trap=%b tpc=%h pc=%h instr=%h",
                     imem_req_valid, instr_valid, trap, trap_pc, PC, Instr);
        end
        reset       = 1'b0;
        model_pc    = RV;
        exp_trap_pc = 32'h0;
        exp_q.delete();
        exp_q.push_back(RV);
    endtask

    task automatic test_sequential;
        fetch_one(32'h0000_0013, 0);
        retire_one(1'b0, 32'h0);
        fetch_one(32'h0000_0013, 0);
        retire_one(1'b0, 32'hDEAD_BEE1);
    endtask

    task automatic test_backpressure;
        fetch_one(32'h0000_0013, 4);
        retire_one(1'b1, 32'h0000_0040);
    endtask

    task automatic test_branch_and_trap;
        fetch_one(32'h00A0_0093, 0);
        retire_one(1'b1, 32'h0000_0042);
        fetch_one(32'h0000_0073, 0);
        retire_one(1'b1, 32'hFFFF_FFFC);
    endtask

    task automatic test_wrap;
        fetch_one(32'h1234_5678, 0);
        retire_one(1'b0, 32'h0);
        fetch_one(32'h0000_0013, 0);
        retire_one(1'b0, 32'h0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] held_pc;
        @(negedge clk);
        held_pc = exp_q.pop_front();
        // Stray response and retire while still in REQ with ready low.
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_0001;
        retire         = 1'b1;
        PCSrc          = 1'b1;
        PCTarget       = 32'h0000_0080;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== held_pc || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_req: got rv=%b addr=%h iv=%b want 1 %h 0",
                     imem_req_valid, imem_addr, instr_valid, held_pc);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        // Response arrived with acceptance: must be ignored, so the DUT stays in WAIT.
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || PC !== held_pc) begin
            n_fail++;
            $display("FAIL stray_wait: got rv=%b iv=%b pc=%h want 0 0 %h",
                     imem_req_valid, instr_valid, PC, held_pc);
        end
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0002;
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b0 || Instr !== 32'h0 || PC !== RV || trap_pc !== 32'h0 ||
            imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got iv=%b instr=%h pc=%h tpc=%h rv=%b",
                     instr_valid, Instr, PC, trap_pc, imem_req_valid);
        end
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        retire         = 1'b0;
        model_pc       = RV;
        exp_trap_pc    = 32'h0;
        exp_q.delete();
        exp_q.push_back(RV);
        fetch_one(32'h0000_0013, 0);
        retire_one(1'b0, 32'h0);
        fetch_one(32'h0000_0013, 0);
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        retire         = 1'b0;
        PCSrc          = 1'b0;
        PCTarget       = 32'h0;
        model_pc       = RV;
        exp_instr      = 32'h0;
        exp_trap_pc    = 32'h0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_and_trap();
        test_wrap();
        test_reset_mid();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
